id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
Decode-to-execute operand stage. It drives the register file read addresses and takes the two 64-bit read values. It forwards pending write-back and EX/MEM results over them, detects load-use hazards and stalls decode. It holds the ID/EX pipeline register toward the ALU behind a valid/ready handshake, and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 64, datapath width
REG_AW, 5, register address width
ZERO_REG, 31, index of the hardwired-zero register (XZR); never forwarded, always reads 0
ALU_OP_W, 4, ALU opcode width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_rn, id_rm, id_rd  in  REG_AW  source 1, source 2 and destination register indices
id_imm  in  DATA_W  sign-extended immediate
id_use_imm  in  1  operand B takes id_imm instead of rm
id_reg_write, id_is_load  in  1  instruction writes rd / instruction is a load
id_alu_op  in  ALU_OP_W  ALU opcode
read_Reg1, read_Reg2  out  REG_AW  register file read addresses; combinational copies of id_rn and id_rm
read_Data1, read_Data2  in  DATA_W  register file read data, combinational
mem_reg_write, mem_is_load  in  1  EX/MEM register contents
mem_rd  in  REG_AW  EX/MEM destination
mem_data  in  DATA_W  EX/MEM ALU result; invalid when mem_is_load=1
wb_reg_write  in  1  MEM/WB write enable; the same value drives the register file reg_Write
wb_rd  in  REG_AW  MEM/WB destination
wb_data  in  DATA_W  MEM/WB write data
flush  in  1  discard the held instruction and the current decode instruction
ex_valid  out  1  ID/EX payload valid
ex_ready  in  1  EX consumes the payload
ex_op_a, ex_op_b, ex_store_data  out  DATA_W  operands; ex_store_data is forwarded rm
ex_rd  out  REG_AW  destination register
ex_reg_write, ex_is_load  out  1  control passed to EX
ex_alu_op  out  ALU_OP_W  ALU opcode
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - ex_valid=0, all ex_* payload=0, stall_count=0, immediately and independent of clk.
  - id_ready evaluates combinationally, with the held slot empty.
- Forwarding, per source s in {rn, rm}, in this priority:
  - s==ZERO_REG: value 0.
  - mem_reg_write && !mem_is_load && mem_rd==s: mem_data.
  - wb_reg_write && wb_rd==s: wb_data. This covers the same-cycle register file write, which the register file only commits at the edge.
  - Otherwise: read_Data1 for rn, read_Data2 for rm.
- Operand selection:
  - ex_op_a = forwarded rn.
  - ex_op_b = id_use_imm ? id_imm : forwarded rm.
  - ex_store_data = forwarded rm.
- Hazard (combinational), match(r) = r!=ZERO_REG && (r==id_rn || r==id_rm):
  - Raised when id_valid and either holds:
    - ex_valid && ex_is_load && ex_reg_write && match(ex_rd)
    - mem_is_load && mem_reg_write && match(mem_rd)
  - A load followed immediately by a dependent instruction costs exactly 2 bubble cycles. The dependency then resolves through wb forwarding.
- Handshake:
  - slot_free = !ex_valid || ex_ready.
  - id_ready = slot_free && !hazard && !flush.
- Register update at rising clk, in this priority:
  1. flush: ex_valid<=0; payload unchanged. flush wins over every other event.
  2. id_valid && id_ready: load the payload, ex_valid<=1. This is zero-bubble back-to-back throughput.
  3. slot_free (no accept, including the hazard case): ex_valid<=0, inserting a bubble.
  4. ex_valid && !ex_ready: hold the payload and ex_valid stable. Operands are never re-forwarded while held.
- stall_count: increments by 1 on every clk where id_valid && hazard && !flush. It saturates at all-ones and does not wrap.
- Decode holds its inputs stable while id_valid && !id_ready. Forwarding is re-evaluated each cycle against the current mem/wb values.
- id_rd==ZERO_REG with id_reg_write=1 passes through unchanged; downstream writes to XZR have no effect.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, REG_AW, ZERO_REG
  - enum alu_op_t
  - packed struct id_ex_t (rd, reg_write, is_load, alu_op, op_a, op_b, store_data); the ID/EX register is one id_ex_t.
- One sub-module, operand_forward: the per-source priority mux above, instantiated for rn and for rm.

Test Plan:
- Reset mid-operation: ex_valid=1 with payload op_a=0x1234, drop reset between edges -> ex_valid=0, ex_op_a=0 immediately; stall_count=0.
- WB bypass: read_Data1=0x5 for X3, wb_reg_write=1, wb_rd=3, wb_data=0xAA, id_rn=3 -> captured ex_op_a=0xAA.
- Priority and XZR:
  - mem_rd=3 with data 0x11 and wb_rd=3 with data 0x22 -> ex_op_a=0x11.
  - id_rn=31 with mem_rd=31, mem_data=0xFF -> ex_op_a=0; a load to X31 causes no stall.
- Load-use: ex holds a load with rd=4, then id_rn=4, ex_ready=1 ->
  - id_ready=0 for 2 cycles, ex_valid=0 for 2 cycles, stall_count +2.
  - On the third cycle the instruction is accepted and ex_op_a = wb_data.
- Backpressure: ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0; ex_* stable despite mem/wb changes; no stall_count increment.
- Flush: flush=1 with ex_valid=1 and id_valid=1 -> next cycle ex_valid=0, the decode instruction is not accepted, stall_count unchanged.
- Saturation: stall_count forced near all-ones, keep hazard asserted -> stall_count holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: widths, ALU opcode enum and the ID/EX pipeline payload.
// Imported by the operand stage and its forwarding mux.
package cpu_pkg;

    localparam int DATA_W   = 64;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;
    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(31);

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_ORR   = 4'h3,
        ALU_EOR   = 4'h4,
        ALU_LSL   = 4'h5,
        ALU_LSR   = 4'h6,
        ALU_ASR   = 4'h7,
        ALU_PASSB = 4'h8
    } alu_op_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
        alu_op_t           alu_op;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] store_data;
    } id_ex_t;

    // True when register r is a real (non-XZR) source of the decoding instruction.
    function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                       input logic [REG_AW-1:0] rn,
                                       input logic [REG_AW-1:0] rm);
        return (r != ZERO_REG) && ((r == rn) || (r == rm));
    endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-source bypass mux: XZR, then EX/MEM ALU result, then MEM/WB data, then register file.
module operand_forward
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_is_load_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    always_comb begin
        fwd_data_o = rf_data_i;
        if (src_i == ZERO_REG) begin
            fwd_data_o = '0;
        end else if (mem_reg_write_i && !mem_is_load_i && (mem_rd_i == src_i)) begin
            // A load's EX/MEM value is an address, not the loaded data.
            fwd_data_o = mem_data_i;
        end else if (wb_reg_write_i && (wb_rd_i == src_i)) begin
            fwd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: forwarding, load-use stall, ID/EX register with
// valid/ready handshake toward the ALU, and a saturating stall-cycle counter.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                id_valid,
    output logic                id_ready,
    input  logic [REG_AW-1:0]   id_rn,
    input  logic [REG_AW-1:0]   id_rm,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic                id_use_imm,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    input  logic [ALU_OP_W-1:0] id_alu_op,

    output logic [REG_AW-1:0]   read_Reg1,
    output logic [REG_AW-1:0]   read_Reg2,
    input  logic [DATA_W-1:0]   read_Data1,
    input  logic [DATA_W-1:0]   read_Data2,

    input  logic                mem_reg_write,
    input  logic                mem_is_load,
    input  logic [REG_AW-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,

    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,

    input  logic                flush,

    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [DATA_W-1:0]   ex_op_a,
    output logic [DATA_W-1:0]   ex_op_b,
    output logic [DATA_W-1:0]   ex_store_data,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_reg_write,
    output logic                ex_is_load,
    output logic [ALU_OP_W-1:0] ex_alu_op,

    output logic [CNT_W-1:0]    stall_count
);

    id_ex_t            ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [REG_AW-1:0] src    [2];
    logic [DATA_W-1:0] rf_val [2];
    logic [DATA_W-1:0] fwd_val[2];

    logic hazard;
    logic slot_free;

    assign read_Reg1 = id_rn;
    assign read_Reg2 = id_rm;

    assign src[0]    = id_rn;
    assign src[1]    = id_rm;
    assign rf_val[0] = read_Data1;
    assign rf_val[1] = read_Data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            operand_forward u_fwd (
                .src_i           (src[gi]),
                .rf_data_i       (rf_val[gi]),
                .mem_reg_write_i (mem_reg_write),
                .mem_is_load_i   (mem_is_load),
                .mem_rd_i        (mem_rd),
                .mem_data_i      (mem_data),
                .wb_reg_write_i  (wb_reg_write),
                .wb_rd_i         (wb_rd),
                .wb_data_i       (wb_data),
                .fwd_data_o      (fwd_val[gi])
            );
        end
    endgenerate

    // A load in ID/EX or EX/MEM has no data yet; a dependent instruction waits until WB.
    assign hazard = id_valid &&
                    ((ex_valid_q && ex_q.is_load && ex_q.reg_write &&
                      reg_match(ex_q.rd, id_rn, id_rm)) ||
                     (mem_is_load && mem_reg_write &&
                      reg_match(mem_rd, id_rn, id_rm)));

    assign slot_free = !ex_valid_q || ex_ready;
    assign id_ready  = slot_free && !hazard && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (id_valid && id_ready) begin
            ex_valid_d       = 1'b1;
            ex_d.rd          = id_rd;
            ex_d.reg_write   = id_reg_write;
            ex_d.is_load     = id_is_load;
            ex_d.alu_op      = alu_op_t'(id_alu_op);
            ex_d.op_a        = fwd_val[0];
            ex_d.op_b        = id_use_imm ? id_imm : fwd_val[1];
            ex_d.store_data  = fwd_val[1];
        end else if (slot_free) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_op_a       = ex_q.op_a;
    assign ex_op_b       = ex_q.op_b;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_is_load    = ex_q.is_load;
    assign ex_alu_op     = ex_q.alu_op;
    assign stall_count   = stall_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized plus directed bench for id_ex_operand_stage against a cycle-level
// reference model; a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid, id_use_imm, id_reg_write, id_is_load;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic [63:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        mem_reg_write, mem_is_load, wb_reg_write, flush, ex_ready;
    logic [4:0]  mem_rd, wb_rd;
    logic [63:0] mem_data, wb_data;
    logic [63:0] rf [32];

    logic        id_ready, ex_valid, ex_reg_write, ex_is_load;
    logic [4:0]  read_Reg1, read_Reg2, ex_rd;
    logic [63:0] read_Data1, read_Data2, ex_op_a, ex_op_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [31:0] stall_count;

    logic        s_id_ready, s_ex_valid, s_ex_reg_write, s_ex_is_load;
    logic [4:0]  s_read_Reg1, s_read_Reg2, s_ex_rd;
    logic [63:0] s_read_Data1, s_read_Data2, s_ex_op_a, s_ex_op_b, s_ex_store_data;
    logic [3:0]  s_ex_alu_op;
    logic [1:0]  s_stall_count;

    assign read_Data1   = rf[read_Reg1];
    assign read_Data2   = rf[read_Reg2];
    assign s_read_Data1 = rf[s_read_Reg1];
    assign s_read_Data2 = rf[s_read_Reg2];

    id_ex_operand_stage #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_alu_op(id_alu_op),
        .read_Reg1(read_Reg1), .read_Reg2(read_Reg2), .read_Data1(read_Data1), .read_Data2(read_Data2),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
    );

    id_ex_operand_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(s_id_ready), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_alu_op(id_alu_op),
        .read_Reg1(s_read_Reg1), .read_Reg2(s_read_Reg2), .read_Data1(s_read_Data1), .read_Data2(s_read_Data2),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(s_ex_valid), .ex_ready(ex_ready), .ex_op_a(s_ex_op_a), .ex_op_b(s_ex_op_b),
        .ex_store_data(s_ex_store_data), .ex_rd(s_ex_rd), .ex_reg_write(s_ex_reg_write),
        .ex_is_load(s_ex_is_load), .ex_alu_op(s_ex_alu_op), .stall_count(s_stall_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model state: what the ID/EX register should hold.
    bit          m_valid, m_rw, m_ld;
    logic [4:0]  m_rd;
    logic [3:0]  m_op;
    logic [63:0] m_a, m_b, m_sd;
    longint      m_cnt;
    int          m_cnt2;
    logic        last_ready;

    function automatic void model_reset();
        m_valid = 0; m_rw = 0; m_ld = 0; m_rd = '0; m_op = '0;
        m_a = '0; m_b = '0; m_sd = '0; m_cnt = 0; m_cnt2 = 0;
    endfunction

    function automatic logic [63:0] model_fwd(input logic [4:0] r);
        if (r == 5'd31) return 64'd0;
        if (mem_reg_write && !mem_is_load && mem_rd == r) return mem_data;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    // Loads still in flight (ID/EX or EX/MEM) whose result a source needs.
    function automatic bit model_hazard();
        logic [4:0] pend[$];
        if (!id_valid) return 0;
        if (m_valid && m_ld && m_rw) pend.push_back(m_rd);
        if (mem_is_load && mem_reg_write) pend.push_back(mem_rd);
        foreach (pend[k])
            if (pend[k] != 5'd31 && (pend[k] == id_rn || pend[k] == id_rm)) return 1;
        return 0;
    endfunction

    task automatic step();
        bit hz, rdy, take;
        logic [63:0] na, nb;
        #1;
        hz   = model_hazard();
        rdy  = (!m_valid || ex_ready) && !hz && !flush;
        take = id_valid && rdy;
        na   = model_fwd(id_rn);
        nb   = model_fwd(id_rm);
        last_ready = id_ready;
        check_val("id_ready", id_ready, rdy);
        check_val("read_Reg1", read_Reg1, id_rn);
        check_val("read_Reg2", read_Reg2, id_rm);
        @(posedge clk);
        #1;
        if (flush) m_valid = 0;
        else if (take) begin
            m_valid = 1; m_rd = id_rd; m_rw = id_reg_write; m_ld = id_is_load; m_op = id_alu_op;
            m_a = na; m_b = id_use_imm ? id_imm : nb; m_sd = nb;
        end else if (!m_valid || ex_ready) m_valid = 0;
        if (hz && !flush) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        check_val("ex_valid", ex_valid, m_valid);
        check_val("ex_op_a", ex_op_a, m_a);
        check_val("ex_op_b", ex_op_b, m_b);
        check_val("ex_store_data", ex_store_data, m_sd);
        check_val("ex_rd", ex_rd, m_rd);
        check_val("ex_reg_write", ex_reg_write, m_rw);
        check_val("ex_is_load", ex_is_load, m_ld);
        check_val("ex_alu_op", ex_alu_op, m_op);
        check_val("stall_count", stall_count, m_cnt);
        check_val("stall_count_sat", s_stall_count, m_cnt2);
        if (take)
            $display("accept rd=%0d rn=%0d rm=%0d op_a=%h op_b=%h stalls=%0d",
                     id_rd, id_rn, id_rm, ex_op_a, ex_op_b, stall_count);
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_use_imm = 0; id_reg_write = 0; id_is_load = 0;
        id_rn = 5'd0; id_rm = 5'd0; id_rd = 5'd0; id_imm = '0; id_alu_op = '0;
        mem_reg_write = 0; mem_is_load = 0; mem_rd = 5'd0; mem_data = '0;
        wb_reg_write = 0; wb_rd = 5'd0; wb_data = '0; flush = 0; ex_ready = 1;
    endtask

    function automatic logic [4:0] pick_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    logic [31:0] cnt0;
    logic [63:0] held_a;
    logic        v1, v2, r1, r2;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {$urandom(), $urandom()};
        clear_inputs();
        model_reset();
        reset = 0;
        #2;
        check_val("reset_ex_valid", ex_valid, 0);
        check_val("reset_stall", stall_count, 0);
        #5 reset = 1;
        @(posedge clk); #1;

        // WB bypass over stale register file data
        rf[3] = 64'h5; id_valid = 1; id_rn = 3; id_rm = 1;
        wb_reg_write = 1; wb_rd = 3; wb_data = 64'hAA;
        step();
        check_val("wb_bypass", ex_op_a, 64'hAA);

        // EX/MEM beats MEM/WB
        mem_reg_write = 1; mem_rd = 3; mem_data = 64'h11; wb_data = 64'h22;
        step();
        check_val("mem_priority", ex_op_a, 64'h11);

        // XZR reads zero even when a producer targets it
        id_rn = 31; mem_rd = 31; mem_data = 64'hFF;
        step();
        check_val("xzr_zero", ex_op_a, 64'h0);
        clear_inputs();
        id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 31; id_rn = 1;
        step();
        id_is_load = 0; id_rd = 7; id_rn = 31;
        step();
        check_val("xzr_no_stall", last_ready, 1);

        // Load-use: two bubbles, then WB forwarding
        clear_inputs();
        cnt0 = stall_count;
        id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 4; id_rn = 1;
        step();
        id_is_load = 0; id_rd = 5; id_rn = 4; id_rm = 2;
        step(); r1 = last_ready; v1 = ex_valid;
        mem_reg_write = 1; mem_is_load = 1; mem_rd = 4; mem_data = 64'hDEAD;
        step(); r2 = last_ready; v2 = ex_valid;
        mem_reg_write = 0; mem_is_load = 0;
        wb_reg_write = 1; wb_rd = 4; wb_data = 64'hBEEF;
        step();
        check_val("lu_ready1", r1, 0);
        check_val("lu_ready2", r2, 0);
        check_val("lu_bubble1", v1, 0);
        check_val("lu_bubble2", v2, 0);
        check_val("lu_stalls", stall_count - cnt0, 2);
        check_val("lu_accept", last_ready, 1);
        check_val("lu_op_a", ex_op_a, 64'hBEEF);

        // Backpressure: held payload is not re-forwarded
        clear_inputs();
        rf[2] = 64'h77; id_valid = 1; id_rn = 2;
        step();
        held_a = ex_op_a;
        check_val("bp_load", held_a, 64'h77);
        cnt0 = stall_count;
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            mem_reg_write = 1; mem_rd = 2; mem_data = {$urandom(), $urandom()};
            wb_reg_write = 1; wb_rd = 2; wb_data = {$urandom(), $urandom()};
            step();
            check_val("bp_ready", last_ready, 0);
            check_val("bp_hold", ex_op_a, 64'h77);
            check_val("bp_valid", ex_valid, 1);
        end
        check_val("bp_stalls", stall_count, cnt0);

        // Flush beats accept and does not count a hazard
        mem_is_load = 1; flush = 1; ex_ready = 0;
        step();
        check_val("flush_ready", last_ready, 0);
        check_val("flush_valid", ex_valid, 0);
        check_val("flush_stalls", stall_count, cnt0);

        // Sustained hazard saturates the narrow counter
        clear_inputs();
        id_valid = 1; id_rn = 6; mem_reg_write = 1; mem_is_load = 1; mem_rd = 6;
        for (int i = 0; i < 6; i++) step();
        check_val("sat_hold", s_stall_count, 2'd3);

        // Reset between edges while the slot holds op_a=0x1234
        clear_inputs();
        rf[1] = 64'h1234; id_valid = 1; id_rn = 1;
        step();
        check_val("pre_reset_a", ex_op_a, 64'h1234);
        id_valid = 0; ex_ready = 0;
        #3 reset = 0;
        #1;
        model_reset();
        check_val("async_valid", ex_valid, 0);
        check_val("async_op_a", ex_op_a, 64'h0);
        check_val("async_stall", stall_count, 0);
        #2 reset = 1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rn         = pick_reg();
            id_rm         = pick_reg();
            id_rd         = pick_reg();
            id_imm        = {$urandom(), $urandom()};
            id_use_imm    = $urandom_range(0, 1) == 1;
            id_reg_write  = $urandom_range(0, 3) != 0;
            id_is_load    = $urandom_range(0, 2) == 0;
            id_alu_op     = 4'($urandom_range(0, 15));
            mem_reg_write = $urandom_range(0, 1) == 1;
            mem_is_load   = $urandom_range(0, 3) == 0;
            mem_rd        = pick_reg();
            mem_data      = {$urandom(), $urandom()};
            wb_reg_write  = $urandom_range(0, 1) == 1;
            wb_rd         = pick_reg();
            wb_data       = {$urandom(), $urandom()};
            flush         = $urandom_range(0, 15) == 0;
            ex_ready      = $urandom_range(0, 3) != 0;
            for (int k = 0; k < 4; k++) rf[k] = {$urandom(), $urandom()};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
